serving_ram_arbiter: RTL and testbench

- Shares one byte-wide serving_ram between the 32-bit instruction bus (ibus, read-only) and the 32-bit data bus (dbus, read/write with byte select).
- Serialises each granted word access into four byte beats on the RAM port, then returns one ack to the winning bus.
- Sits between the core's ibus/dbus and the SoC SRAM.

---
 rtl/serving_ram_arb_pkg.sv | 10 +
 rtl/serving_ram_arb_pick.sv | 23 ++
 rtl/serving_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_serving_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serving_ram_arb_pkg.sv
// serving_ram_arb_pkg: shared FSM states, beat count and grant encoding for the RAM arbiter
package serving_ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    typedef enum logic {GNT_IBUS = 1'b0, GNT_DBUS = 1'b1} gnt_t;

    localparam int BEATS = 4;

endpackage

// File: rtl/serving_ram_arb_pick.sv
// serving_ram_arb_pick: winner select for ibus/dbus; SERVING_RAM_ARB_RR_EN selects round-robin over fixed dbus priority
module serving_ram_arb_pick
    import serving_ram_arb_pkg::*;
(
    input  logic i_ibus_cyc,
    input  logic i_dbus_cyc,
`ifdef SERVING_RAM_ARB_RR_EN
    input  gnt_t i_last,
`endif
    output gnt_t o_gnt
);

    always_comb begin
`ifdef SERVING_RAM_ARB_RR_EN
        o_gnt = !i_dbus_cyc ? GNT_IBUS :
                !i_ibus_cyc ? GNT_DBUS :
                (i_last == GNT_DBUS) ? GNT_IBUS : GNT_DBUS;
`else
        o_gnt = i_dbus_cyc ? GNT_DBUS : GNT_IBUS;
`endif
    end

endmodule

// File: rtl/serving_ram_arbiter.sv
// serving_ram_arbiter: serialises ibus/dbus word accesses onto a byte-wide RAM; SERVING_RAM_ARB_RR_EN enables round-robin arbitration
module serving_ram_arbiter
    import serving_ram_arb_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [aw-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [aw-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [aw-1:0] o_ram_waddr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_wen,
    output logic [aw-1:0] o_ram_raddr,
    output logic          o_ram_ren,
    input  logic [7:0]    i_ram_rdata
);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    gnt_t          gnt_q, gnt_d;
    logic [aw-3:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    lane;
    gnt_t          pick;
    logic          unused_adr;

    assign unused_adr = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};
    // RAM data lags the read strobe by one cycle, so beat cnt delivers byte cnt-1
    assign lane = cnt_q[1:0] - 2'd1;

`ifdef SERVING_RAM_ARB_RR_EN
    gnt_t last_q, last_d;

    serving_ram_arb_pick u_pick (
        .i_ibus_cyc (i_ibus_cyc),
        .i_dbus_cyc (i_dbus_cyc),
        .i_last     (last_q),
        .o_gnt      (pick)
    );
`else
    serving_ram_arb_pick u_pick (
        .i_ibus_cyc (i_ibus_cyc),
        .i_dbus_cyc (i_dbus_cyc),
        .o_gnt      (pick)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
`ifdef SERVING_RAM_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: if (i_ibus_cyc || i_dbus_cyc) begin
                gnt_d   = pick;
                cnt_d   = '0;
                adr_d   = (pick == GNT_DBUS) ? i_dbus_adr[aw-1:2] : i_ibus_adr[aw-1:2];
                we_d    = (pick == GNT_DBUS) && i_dbus_we;
                sel_d   = i_dbus_sel;
                dat_d   = i_dbus_dat;
                state_d = we_d ? WR : RD;
`ifdef SERVING_RAM_ARB_RR_EN
                last_d  = pick;
`endif
            end
            RD: begin
                if (cnt_q != '0)
                    rdata_d[{lane, 3'b000} +: 8] = i_ram_rdata;
                state_d = (cnt_q == 3'(BEATS)) ? ACK : RD;
                cnt_d   = (cnt_q == 3'(BEATS)) ? cnt_q : cnt_q + 3'd1;
            end
            WR: begin
                state_d = (cnt_q == 3'(BEATS - 1)) ? ACK : WR;
                cnt_d   = cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= GNT_IBUS;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
`ifdef SERVING_RAM_ARB_RR_EN
            last_q  <= GNT_DBUS;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
`ifdef SERVING_RAM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_ram_raddr = {adr_q, cnt_q[1:0]};
    assign o_ram_waddr = {adr_q, cnt_q[1:0]};
    assign o_ram_ren   = (state_q == RD) && (cnt_q != 3'(BEATS));
    assign o_ram_wen   = (state_q == WR) && sel_q[cnt_q[1:0]];
    assign o_ram_wdata = dat_q[{cnt_q[1:0], 3'b000} +: 8];
    assign o_ibus_ack  = (state_q == ACK) && (gnt_q == GNT_IBUS);
    assign o_dbus_ack  = (state_q == ACK) && (gnt_q == GNT_DBUS);
    assign o_ibus_rdt  = rdata_q;
    assign o_dbus_rdt  = rdata_q;

endmodule

// File: tb/tb_serving_ram_arbiter.sv
// tb_serving_ram_arbiter: table, corner-case and random checks of serving_ram_arbiter against a byte-array model
module tb_serving_ram_arbiter;

`ifdef SERVING_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [7:0]  i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [7:0]  o_ram_waddr, o_ram_raddr, o_ram_wdata;
    logic        o_ram_wen, o_ram_ren;
    logic [7:0]  ram_rdata = '0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       ld = 1'b0;
    logic [7:0] ld_a = '0, ld_d = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        logic [7:0]  adr;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          corrupt;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t tbl [8];

    serving_ram_arbiter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ibus_adr  (i_ibus_adr),
        .i_ibus_cyc  (i_ibus_cyc),
        .o_ibus_rdt  (o_ibus_rdt),
        .o_ibus_ack  (o_ibus_ack),
        .i_dbus_adr  (i_dbus_adr),
        .i_dbus_dat  (i_dbus_dat),
        .i_dbus_sel  (i_dbus_sel),
        .i_dbus_we   (i_dbus_we),
        .i_dbus_cyc  (i_dbus_cyc),
        .o_dbus_rdt  (o_dbus_rdt),
        .o_dbus_ack  (o_dbus_ack),
        .o_ram_waddr (o_ram_waddr),
        .o_ram_wdata (o_ram_wdata),
        .o_ram_wen   (o_ram_wen),
        .o_ram_raddr (o_ram_raddr),
        .o_ram_ren   (o_ram_ren),
        .i_ram_rdata (ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // SRAM behaviour: write on strobe, registered read data one cycle after ren
    always @(posedge i_clk) begin
        if (ld)
            mem[ld_a] <= ld_d;
        else if (o_ram_wen)
            mem[o_ram_waddr] <= o_ram_wdata;
        if (o_ram_ren)
            ram_rdata <= mem[o_ram_raddr];
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [91:0] all_outs();
        return {o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_ram_waddr,
                o_ram_wdata, o_ram_wen, o_ram_raddr, o_ram_ren};
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
                ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    // one access from an idle arbiter; checks ack latency, every beat, the other bus's ack and read data
    task automatic run(input string nm, input bit is_d, input logic [7:0] adr, input bit we,
                       input logic [3:0] sel, input logic [31:0] dat, input bit corrupt,
                       input logic [31:0] exp_rdt);
        int o, lat;
        bit done, bad, wr;
        logic [31:0] rdt;
        logic [7:0] ba;
        wr = is_d && we;
        if (is_d) begin
            i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we; i_dbus_cyc = 1'b1;
        end else begin
            i_ibus_adr = adr; i_ibus_cyc = 1'b1;
        end
        o = 0; lat = -1; done = 1'b0; bad = 1'b0; rdt = '0;
        while (!done && o < 20) begin
            @(negedge i_clk);
            ba = {adr[7:2], 2'(o - 1)};
            if (o_ram_ren !== (!wr && o >= 1 && o <= 4)) bad = 1'b1;
            if (o_ram_wen !== (wr && o >= 1 && o <= 4 && sel[(o - 1) & 3])) bad = 1'b1;
            if (o_ram_ren && o_ram_raddr !== ba) bad = 1'b1;
            if (o_ram_wen && (o_ram_waddr !== ba || o_ram_wdata !== dat[8 * ((o - 1) & 3) +: 8])) bad = 1'b1;
            if (is_d ? o_ibus_ack : o_dbus_ack) bad = 1'b1;
            if (is_d ? o_dbus_ack : o_ibus_ack) begin
                done = 1'b1;
                lat = o;
                rdt = is_d ? o_dbus_rdt : o_ibus_rdt;
            end else begin
                if (corrupt && o == 2) begin
                    i_dbus_adr = ~adr;
                    i_dbus_dat = ~dat;
                end
                o++;
            end
        end
        chk({nm, " latency"}, 96'(lat), wr ? 96'd5 : 96'd6);
        chk({nm, " beats"}, 96'(bad), 96'd0);
        if (!wr) chk({nm, " rdata"}, 96'(rdt), 96'(exp_rdt));
        if (wr)
            for (int k = 0; k < 4; k++)
                if (sel[k]) ref_mem[{adr[7:2], 2'(k)}] = dat[8 * k +: 8];
        @(posedge i_clk);
        #1;
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
    endtask

    // both buses request from reset; drop=1 releases the winner after its ack
    task automatic contend(input bit drop);
        bit last, exp, got, both;
        int w;
        do_reset();
        last = 1'b1;
        i_ibus_adr = 8'h10; i_dbus_adr = 8'h20; i_dbus_we = 1'b0;
        i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
        for (int k = 0; k < (drop ? 2 : 4); k++) begin
            both = i_ibus_cyc && i_dbus_cyc;
            exp = both ? (RR ? !last : 1'b1) : i_dbus_cyc;
            last = exp;
            w = 0;
            while (!(o_ibus_ack || o_dbus_ack) && w < 20) begin
                @(negedge i_clk);
                w++;
            end
            got = o_dbus_ack;
            chk($sformatf("contend%0d grant%0d ack seen", drop, k), 96'(o_ibus_ack || o_dbus_ack), 96'd1);
            chk($sformatf("contend%0d grant%0d winner", drop, k), 96'(got), 96'(exp));
            @(posedge i_clk);
            #1;
            if (drop) begin
                if (got) i_dbus_cyc = 1'b0;
                else i_ibus_cyc = 1'b0;
            end
        end
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        repeat (8) @(posedge i_clk);
        #1;
    endtask

    initial begin
        bit seen;
        bit is_d, we, cor;
        logic [7:0] adr;
        logic [3:0] sel;
        logic [31:0] dat;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22; ref_mem[8'h12] = 8'h33; ref_mem[8'h13] = 8'h44;
        ref_mem[8'h20] = 8'h01; ref_mem[8'h21] = 8'h02; ref_mem[8'h22] = 8'h03; ref_mem[8'h23] = 8'h04;

        tbl[0] = '{1'b0, 8'h10, 1'b0, 4'b0000, 32'h0,          1'b0, 32'h44332211};
        tbl[1] = '{1'b1, 8'h20, 1'b1, 4'b0101, 32'hAABBCCDD,   1'b0, 32'h0};
        tbl[2] = '{1'b1, 8'h20, 1'b0, 4'b1111, 32'h0,          1'b0, 32'h04BB02DD};
        tbl[3] = '{1'b0, 8'h23, 1'b0, 4'b0000, 32'h0,          1'b0, 32'h04BB02DD};
        tbl[4] = '{1'b1, 8'h10, 1'b1, 4'b0000, 32'hFFFFFFFF,   1'b0, 32'h0};
        tbl[5] = '{1'b0, 8'h10, 1'b0, 4'b0000, 32'h0,          1'b0, 32'h44332211};
        tbl[6] = '{1'b1, 8'h30, 1'b1, 4'b1111, 32'h12345678,   1'b1, 32'h0};
        tbl[7] = '{1'b1, 8'h31, 1'b0, 4'b0000, 32'h0,          1'b0, 32'h12345678};

        i_rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld = 1'b1; ld_a = 8'(i); ld_d = ref_mem[i];
            @(posedge i_clk);
            #1;
        end
        ld = 1'b0;
        @(negedge i_clk);
        chk("reset outputs", 96'(all_outs()), 96'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 8; i++)
            run($sformatf("vec%0d", i), tbl[i].is_d, tbl[i].adr, tbl[i].we, tbl[i].sel,
                tbl[i].dat, tbl[i].corrupt, tbl[i].exp_rdt);

        contend(1'b1);
        contend(1'b0);

        do_reset();
        @(posedge i_clk);
        #1;
        i_ibus_adr = 8'h10;
        i_ibus_cyc = 1'b1;
        seen = 1'b0;
        for (int o = 0; o < 4; o++) begin
            @(negedge i_clk);
            seen |= o_ibus_ack | o_dbus_ack;
            if (o == 3) i_rst_n = 1'b0;
        end
        @(negedge i_clk);
        seen |= o_ibus_ack | o_dbus_ack;
        chk("abort outputs", 96'(all_outs()), 96'd0);
        chk("abort ack", 96'(seen), 96'd0);
        i_ibus_cyc = 1'b0;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run("post-abort", 1'b0, 8'h10, 1'b0, 4'b0, 32'h0, 1'b0, rd_word(8'h10));

        for (int i = 0; i < 40; i++) begin
            is_d = 1'($urandom);
            adr = 8'($urandom);
            we = is_d && 1'($urandom);
            sel = 4'($urandom);
            dat = $urandom;
            cor = is_d && ($urandom_range(3) == 0);
            run($sformatf("rand%0d", i), is_d, adr, we, sel, dat, cor, rd_word(adr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
